// File: rtl/mat_stream_packer_if.sv
// Bundle of the packer's handshake and data signals.
// Every channel follows the same valid/ready rule. A transfer happens on a
// rising clk edge where valid and ready are both high. The source holds valid
// and data stable until that edge. ready may depend on the sink's own state.
// ready never depends on the valid of the same channel.
// The slave modport is the packer. The master modport is the feeder/consumer side.
interface mat_stream_packer_if #(
  parameter int BW = 2
);
  logic              start;
  logic              a_valid;
  logic [31:0]       a_data;
  logic              a_ready;
  logic              b_valid;
  logic [31:0]       b_data;
  logic              b_ready;
  logic              out_valid;
  logic [32*BW-1:0]  out_stream;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  modport slave (
    input  start, a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_stream, out_last, busy, done,
           dbg_state
  );

  modport master (
    output start, a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_stream, out_last, busy, done,
           dbg_state
  );
endinterface

// File: rtl/mat_stream_packer.sv
// Feeds the systolic array input stream. All of A (row-major) is sent first,
// then all of B (column-major). The words are packed into BW-word beats.
// Lane 0 holds the earliest word. There is no padding between A and B. The
// unused lanes of the last beat are zero, and that beat carries out_last.
module mat_stream_packer #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int K  = 2,
  parameter int BW = 2
) (
  input logic                clk,
  input logic                nrst,
  mat_stream_packer_if.slave bus
);

  localparam int A_WORDS = M * N;
  localparam int B_WORDS = K * N;
  localparam int MAX_MK  = (M > K) ? M : K;
  localparam int CW      = $clog2(MAX_MK * N) + 1;
  localparam int LW      = (BW > 1) ? $clog2(BW) : 1;
  localparam int DW      = 32 * BW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] word_cnt;
  logic [LW-1:0] lane;
  logic [DW-1:0] asm_reg;
  logic [DW-1:0] out_stream_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic          done_r;

  logic          in_a;
  logic          in_b;
  logic          last_in_phase;
  logic          lane_full;
  logic          completing;
  logic          slot_free;
  logic          a_take;
  logic          b_take;
  logic          take;
  logic [31:0]   word;
  logic [DW-1:0] beat_next;

  // Decode the phase and decide whether the next word closes a beat.
  always_comb begin
    in_a          = (state == LOAD_A);
    in_b          = (state == LOAD_B);
    last_in_phase = in_a ? (word_cnt == CW'(A_WORDS - 1))
                         : (word_cnt == CW'(B_WORDS - 1));
    lane_full     = (lane == LW'(BW - 1));
    // The final B word is word T, so it closes the beat even if lanes remain.
    completing    = lane_full | (in_b & last_in_phase);
    slot_free     = ~out_valid_r | bus.out_ready;
    // A word that does not close a beat can always go into the assembly
    // register. A word that closes a beat also needs the output slot.
    bus.a_ready   = in_a & (slot_free | ~completing);
    bus.b_ready   = in_b & (slot_free | ~completing);
    a_take        = bus.a_valid & bus.a_ready;
    b_take        = bus.b_valid & bus.b_ready;
    take          = a_take | b_take;
    word          = in_b ? bus.b_data : bus.a_data;
  end

  // Merge the incoming word into its lane. Higher lanes stay zero.
  always_comb begin
    beat_next = asm_reg;
    for (int i = 0; i < BW; i++) begin
      if (lane == LW'(i)) begin
        beat_next[i*32 +: 32] = word;
      end
    end
  end

  // Phase FSM, counters, assembly register and the registered output slot.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      lane         <= '0;
      asm_reg      <= '0;
      out_stream_r <= '0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Drain first. A completing word later in this block may refill the
      // slot in the same cycle.
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD_A;
            word_cnt <= '0;
            lane     <= '0;
            asm_reg  <= '0;
          end
        end

        LOAD_A, LOAD_B: begin
          if (take) begin
            if (completing) begin
              out_stream_r <= beat_next;
              out_valid_r  <= 1'b1;
              out_last_r   <= in_b & last_in_phase;
              asm_reg      <= '0;
              lane         <= '0;
            end else begin
              asm_reg <= beat_next;
              lane    <= lane + LW'(1);
            end

            // The lane index is not reset here, so a beat can hold both
            // A and B words.
            if (last_in_phase) begin
              word_cnt <= '0;
              state    <= in_a ? LOAD_B : FLUSH;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end

        FLUSH: begin
          if (out_valid_r && bus.out_ready && out_last_r) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Drive the registered outputs and status onto the bus.
  always_comb begin
    bus.out_valid  = out_valid_r;
    bus.out_stream = out_stream_r;
    bus.out_last   = out_last_r;
    bus.busy       = (state != IDLE);
    bus.done       = done_r;
    bus.dbg_state  = state;
  end

endmodule

// File: tb/tb_mat_stream_packer.sv
// Bench for mat_stream_packer.
// Three instances are used:
//   u0 has M=N=K=2, BW=2.
//   u1 has M=1, N=3, K=1, BW=2.
//   u2 has M=1, N=3, K=1, BW=4.
// The drivers push the expected beats into per-instance queues. The monitors
// pop those queues and compare whenever a beat handshakes.
module tb_mat_stream_packer;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mat_stream_packer_if #(.BW(2)) if0 ();
  mat_stream_packer_if #(.BW(2)) if1 ();
  mat_stream_packer_if #(.BW(4)) if2 ();

  mat_stream_packer #(.M(2), .N(2), .K(2), .BW(2)) u0 (.clk(clk), .nrst(nrst), .bus(if0));
  mat_stream_packer #(.M(1), .N(3), .K(1), .BW(2)) u1 (.clk(clk), .nrst(nrst), .bus(if1));
  mat_stream_packer #(.M(1), .N(3), .K(1), .BW(4)) u2 (.clk(clk), .nrst(nrst), .bus(if2));

  // Each entry is {last, data zero-extended to 128 bits}.
  logic [128:0] exp0_q[$];
  logic [128:0] exp1_q[$];
  logic [128:0] exp2_q[$];
  logic [31:0]  word_q[$];

  int done_cnt0 = 0, last_cnt0 = 0;
  int done_cnt1 = 0, last_cnt1 = 0;
  int done_cnt2 = 0, last_cnt2 = 0;

  // ---------------- checking helpers ----------------
  task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int which, input logic last, input logic [127:0] data);
    case (which)
      0:       exp0_q.push_back({last, data});
      1:       exp1_q.push_back({last, data});
      default: exp2_q.push_back({last, data});
    endcase
  endtask

  // Reference packing of word_q into bw-word beats (lane 0 = earliest word).
  task automatic build_exp(input int bw, input int which);
    logic [127:0] beat = '0;
    int ln = 0;
    int n = word_q.size();
    for (int i = 0; i < n; i++) begin
      beat[ln*32 +: 32] = word_q[i];
      ln++;
      if (ln == bw || i == n - 1) begin
        push_exp(which, (i == n - 1), beat);
        beat = '0;
        ln = 0;
      end
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_start0();
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] d);
    int t = 0;
    if0.a_valid = 1'b1;
    if0.a_data  = d;
    #1;
    while (!if0.a_ready && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    check1("a_accept_in_time", (t < 100), 1'b1);
    @(posedge clk); #1;
    if0.a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] d);
    int t = 0;
    if0.b_valid = 1'b1;
    if0.b_data  = d;
    #1;
    while (!if0.b_ready && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    check1("b_accept_in_time", (t < 100), 1'b1);
    @(posedge clk); #1;
    if0.b_valid = 1'b0;
  endtask

  // Offers one word to both u1 and u2. The word is withdrawn from each one
  // separately once that instance has taken it.
  task automatic feed12(input logic is_b, input logic [31:0] d);
    logic ok1 = 1'b0;
    logic ok2 = 1'b0;
    logic r1, r2;
    int t = 0;
    if (is_b) begin
      if1.b_valid = 1'b1; if1.b_data = d; if2.b_valid = 1'b1; if2.b_data = d;
    end else begin
      if1.a_valid = 1'b1; if1.a_data = d; if2.a_valid = 1'b1; if2.a_data = d;
    end
    while (!(ok1 && ok2) && t < 50) begin
      #1;
      r1 = is_b ? if1.b_ready : if1.a_ready;
      r2 = is_b ? if2.b_ready : if2.a_ready;
      @(posedge clk); #1;
      if (r1 && !ok1) begin
        ok1 = 1'b1;
        if (is_b) if1.b_valid = 1'b0; else if1.a_valid = 1'b0;
      end
      if (r2 && !ok2) begin
        ok2 = 1'b1;
        if (is_b) if2.b_valid = 1'b0; else if2.a_valid = 1'b0;
      end
      t++;
    end
    check1("feed12_in_time", ok1 && ok2, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || exp2_q.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    check1("drain_in_time", (t < 300), 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset0();
    checkw("rst_out_stream", 128'(if0.out_stream), 128'h0);
    check1("rst_out_valid", if0.out_valid, 1'b0);
    check1("rst_out_last", if0.out_last, 1'b0);
    check1("rst_a_ready", if0.a_ready, 1'b0);
    check1("rst_b_ready", if0.b_ready, 1'b0);
    check1("rst_busy", if0.busy, 1'b0);
    check1("rst_done", if0.done, 1'b0);
    checkw("rst_state", 128'(if0.dbg_state), 128'h0);
  endtask

  // ---------------- monitor for u0 ----------------
  initial begin : mon0
    logic         stall0;
    logic         last_hs0;
    logic [63:0]  held0;
    logic         held_last0;
    logic [128:0] e;
    stall0 = 1'b0;
    last_hs0 = 1'b0;
    held0 = '0;
    held_last0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        stall0 = 1'b0;
        last_hs0 = 1'b0;
      end else begin
        if (stall0) begin
          checkw("hold_stream", 128'(if0.out_stream), 128'(held0));
          check1("hold_last", if0.out_last, held_last0);
          check1("hold_valid", if0.out_valid, 1'b1);
        end
        if (last_hs0 || if0.done) check1("done_pulse", if0.done, last_hs0);
        if (last_hs0) check1("busy_falls_with_done", if0.busy, 1'b0);
        if (if0.a_ready || if0.b_ready)
          check1("ready_exclusive", if0.a_ready & if0.b_ready, 1'b0);
        if (if0.done) done_cnt0++;
        last_hs0 = 1'b0;
        if (if0.out_valid && if0.out_ready) begin
          if (exp0_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat0_unexpected actual=%0h required=none", if0.out_stream);
          end else begin
            e = exp0_q.pop_front();
            checkw("beat0_data", 128'(if0.out_stream), e[127:0]);
            check1("beat0_last", if0.out_last, e[128]);
          end
          if (if0.out_last) begin
            last_cnt0++;
            last_hs0 = 1'b1;
          end
        end
        stall0 = if0.out_valid && !if0.out_ready;
        held0 = if0.out_stream;
        held_last0 = if0.out_last;
      end
    end
  end

  // ---------------- monitor for u1 / u2 ----------------
  initial begin : mon12
    logic [128:0] e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (if1.done) done_cnt1++;
        if (if2.done) done_cnt2++;
        if (if1.out_valid && if1.out_ready) begin
          if (exp1_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat1_unexpected actual=%0h required=none", if1.out_stream);
          end else begin
            e = exp1_q.pop_front();
            checkw("beat1_data", 128'(if1.out_stream), e[127:0]);
            check1("beat1_last", if1.out_last, e[128]);
          end
          if (if1.out_last) last_cnt1++;
        end
        if (if2.out_valid && if2.out_ready) begin
          if (exp2_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat2_unexpected actual=%0h required=none", if2.out_stream);
          end else begin
            e = exp2_q.pop_front();
            checkw("beat2_data", if2.out_stream, e[127:0]);
            check1("beat2_last", if2.out_last, e[128]);
          end
          if (if2.out_last) last_cnt2++;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    nrst = 1'b0;
    if0.start = 1'b0; if0.a_valid = 1'b0; if0.a_data = '0;
    if0.b_valid = 1'b0; if0.b_data = '0; if0.out_ready = 1'b1;
    if1.start = 1'b0; if1.a_valid = 1'b0; if1.a_data = '0;
    if1.b_valid = 1'b0; if1.b_data = '0; if1.out_ready = 1'b1;
    if2.start = 1'b0; if2.a_valid = 1'b0; if2.a_data = '0;
    if2.b_valid = 1'b0; if2.b_data = '0; if2.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset0();
    check1("rst_u1_valid", if1.out_valid, 1'b0);
    check1("rst_u2_busy", if2.busy, 1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Test 1: 2x2 by 2x2, BW=2. The expected beats are written out by hand.
    push_exp(0, 1'b0, 128'h40000000_3F800000);
    push_exp(0, 1'b0, 128'h40800000_40400000);
    push_exp(0, 1'b0, 128'h40C00000_40A00000);
    push_exp(0, 1'b1, 128'h41000000_40E00000);
    do_start0();
    check1("busy_after_start", if0.busy, 1'b1);
    check1("a_ready_in_load_a", if0.a_ready, 1'b1);
    push_a(32'h3F800000); push_a(32'h40000000); push_a(32'h40400000); push_a(32'h40800000);
    push_b(32'h40A00000); push_b(32'h40C00000); push_b(32'h40E00000); push_b(32'h41000000);
    wait_drain();
    checki("done_count_t1", done_cnt0, 1);
    checki("last_count_t1", last_cnt0, 1);

    // Test 2: backpressure. out_ready is low before the first beat appears.
    if0.out_ready = 1'b0;
    word_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    build_exp(2, 0);
    do_start0();
    fork
      begin
        for (int i = 0; i < 4; i++) push_a(word_q[i]);
        for (int i = 4; i < 8; i++) push_b(word_q[i]);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        check1("bp_out_valid", if0.out_valid, 1'b1);
        checkw("bp_first_beat", 128'(if0.out_stream), 128'h000000A2_000000A1);
        check1("bp_a_ready_low", if0.a_ready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkw("bp_first_beat_later", 128'(if0.out_stream), 128'h000000A2_000000A1);
        if0.out_ready = 1'b1;
      end
    join
    wait_drain();
    checki("done_count_t2", done_cnt0, 2);
    checki("last_count_t2", last_cnt0, 2);

    // Test 3: B is offered early, during LOAD_A. A stray start is also
    // pulsed in LOAD_A.
    word_q = '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
    build_exp(2, 0);
    do_start0();
    fork
      begin
        for (int i = 4; i < 8; i++) push_b(word_q[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_a(word_q[i]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check1("b_ready_low_in_load_a", if0.b_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
      end
    join
    wait_drain();
    checki("done_count_t3", done_cnt0, 3);
    checki("last_count_t3", last_cnt0, 3);

    // Test 4: reset in the middle of LOAD_B, then a fresh transfer.
    word_q = '{32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hF1, 32'hF2, 32'hF3, 32'hF4};
    build_exp(2, 0);
    do_start0();
    for (int i = 0; i < 4; i++) push_a(word_q[i]);
    push_b(word_q[4]);
    checkw("dbg_state_load_b", 128'(if0.dbg_state), 128'h2);
    checki("pending_beats_before_reset", exp0_q.size(), 2);
    nrst = 1'b0;
    #1;
    check_reset0();
    exp0_q.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    word_q = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h81, 32'h82, 32'h83, 32'h84};
    build_exp(2, 0);
    do_start0();
    for (int i = 0; i < 4; i++) push_a(word_q[i]);
    for (int i = 4; i < 8; i++) push_b(word_q[i]);
    wait_drain();
    checki("done_count_t4", done_cnt0, 4);
    checki("last_count_t4", last_cnt0, 4);

    // Test 5: M=1, N=3, K=1. The BW=2 instance shows a beat that holds both
    // A and B words. The BW=4 instance shows zero lanes in the last beat.
    push_exp(1, 1'b0, 128'h40000000_3F800000);
    push_exp(1, 1'b0, 128'h40800000_40400000);
    push_exp(1, 1'b1, 128'h40C00000_40A00000);
    push_exp(2, 1'b0, 128'h40800000_40400000_40000000_3F800000);
    push_exp(2, 1'b1, 128'h00000000_00000000_40C00000_40A00000);
    if1.start = 1'b1; if2.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if2.start = 1'b0;
    feed12(1'b0, 32'h3F800000);
    feed12(1'b0, 32'h40000000);
    feed12(1'b0, 32'h40400000);
    feed12(1'b1, 32'h40800000);
    feed12(1'b1, 32'h40A00000);
    feed12(1'b1, 32'h40C00000);
    wait_drain();
    checki("done_count_u1", done_cnt1, 1);
    checki("last_count_u1", last_cnt1, 1);
    checki("done_count_u2", done_cnt2, 1);
    checki("last_count_u2", last_cnt2, 1);
    check1("u1_idle_at_end", if1.busy, 1'b0);
    check1("u2_idle_at_end", if2.busy, 1'b0);

    checki("exp0_left", exp0_q.size(), 0);
    checki("exp1_left", exp1_q.size(), 0);
    checki("exp2_left", exp2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
